// File: rtl/pic_ctl.sv
// pic_ctl: 8259-style programmable interrupt controller.
//
// Request lines are latched into IRR (edge or level), qualified by IMR and by
// the in-service register ISR under fixed priority (line 0 highest). The
// winning line is delivered as one vector at a time over a toggle handshake.
// Programming goes through the usual ICW1..ICW4 init sequence and OCW1..OCW3.
//
// Ports
//   clock     in   host clock, all logic on posedge
//   resetn    in   synchronous active-low reset
//   port_clk  in   one-cycle port access strobe
//   port      in   16-bit port address (PORT_BASE = command, PORT_BASE+1 = data)
//   port_w    in   1 = write, 0 = read
//   port_o    in   write data from the CPU
//   port_i    out  registered read data (IRR/ISR at PORT_BASE, IMR at PORT_BASE+1)
//   irq_in    in   request lines, synchronous to clock
//   intr      out  request toggle; a request is outstanding while intr != intr_ack
//   intr_ack  in   CPU acknowledge toggle (copy of intr once the vector is taken)
//   intr_vec  out  base | line, stable while a request is outstanding
//
// Config FSM
//   state  | meaning
//   READY  | init done; data-port writes load IMR
//   W_ICW2 | ICW1 seen, next data write is the vector base
//   W_ICW3 | waiting for ICW3 (data ignored, no cascade)
//   W_ICW4 | waiting for ICW4 (auto-EOI select)
module pic_ctl #(
    parameter int          NUM_IRQ   = 8,
    parameter logic [15:0] PORT_BASE = 16'h20,
    parameter logic [7:0]  VEC_RESET = 8'h08
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               port_clk,
    input  logic [15:0]        port,
    input  logic               port_w,
    input  logic [7:0]         port_o,
    output logic [7:0]         port_i,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               intr,
    input  logic               intr_ack,
    output logic [7:0]         intr_vec
);

    localparam logic [1:0] READY  = 2'd0;
    localparam logic [1:0] W_ICW2 = 2'd1;
    localparam logic [1:0] W_ICW3 = 2'd2;
    localparam logic [1:0] W_ICW4 = 2'd3;

    localparam logic [15:0] PORT_DATA = PORT_BASE + 16'd1;

    logic [NUM_IRQ-1:0] irr, isr, imr, irq_prev;
    logic [NUM_IRQ-1:0] irr_nxt, isr_nxt, irq_rise;
    logic [NUM_IRQ-1:0] pick_mask, ns_mask, spec_mask;
    logic [4:0]         base_hi;
    logic [1:0]         cfg_state;
    logic               level_mode, aeoi, rd_isr;
    logic               icw1_sngl, icw1_ic4;

    logic       sel_cmd, sel_data;
    logic       wr_cmd, wr_data, rd_cmd, rd_data;
    logic       wr_icw1, wr_ocw2, wr_ocw3;
    logic       found, ns_found, isr_seen, issue;
    logic [2:0] pick_idx;
    logic [7:0] irr_rd, isr_rd, imr_rd;

    assign sel_cmd  = (port == PORT_BASE);
    assign sel_data = (port == PORT_DATA);
    assign wr_cmd   = port_clk & port_w & sel_cmd;
    assign wr_data  = port_clk & port_w & sel_data;
    assign rd_cmd   = port_clk & ~port_w & sel_cmd;
    assign rd_data  = port_clk & ~port_w & sel_data;
    assign wr_icw1  = wr_cmd & port_o[4];
    assign wr_ocw2  = wr_cmd & (port_o[4:3] == 2'b00);
    assign wr_ocw3  = wr_cmd & (port_o[4:3] == 2'b01);

    assign irq_rise = irq_in & ~irq_prev;

    // Lowest eligible line, lowest in-service line (non-specific EOI target)
    // and the one-hot mask for a specific EOI, all in one pass.
    always_comb begin
        found     = 1'b0;
        ns_found  = 1'b0;
        isr_seen  = 1'b0;
        pick_idx  = 3'd0;
        pick_mask = '0;
        ns_mask   = '0;
        spec_mask = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            isr_seen = isr_seen | isr[i];
            if (!found && irr[i] && !imr[i] && !isr_seen) begin
                found        = 1'b1;
                pick_idx     = 3'(i);
                pick_mask[i] = 1'b1;
            end
            if (!ns_found && isr[i]) begin
                ns_found   = 1'b1;
                ns_mask[i] = 1'b1;
            end
            if (port_o[2:0] == 3'(i)) begin
                spec_mask[i] = 1'b1;
            end
        end
    end

    // No issue in the ICW1 cycle: ICW1 wipes ISR, so the issued line would
    // otherwise be in flight with no in-service record behind it.
    assign issue = (intr == intr_ack) & found & ~wr_icw1;

    always_comb begin
        irr_nxt = irr;
        isr_nxt = isr;
        if (wr_ocw2 && port_o[7:5] == 3'b001) begin
            isr_nxt = isr_nxt & ~ns_mask;
        end else if (wr_ocw2 && port_o[7:5] == 3'b011) begin
            isr_nxt = isr_nxt & ~spec_mask;
        end
        if (issue) begin
            irr_nxt = irr_nxt & ~pick_mask;
            if (!aeoi) begin
                isr_nxt = isr_nxt | pick_mask;
            end
        end
        // A fresh edge on the line being issued re-arms it.
        if (level_mode) begin
            irr_nxt = irq_in;
        end else begin
            irr_nxt = irr_nxt | irq_rise;
        end
        if (wr_icw1) begin
            irr_nxt = '0;
            isr_nxt = '0;
        end
    end

    always_comb begin
        irr_rd = '0;
        isr_rd = '0;
        imr_rd = '0;
        irr_rd[NUM_IRQ-1:0] = irr;
        isr_rd[NUM_IRQ-1:0] = isr;
        imr_rd[NUM_IRQ-1:0] = imr;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            intr       <= 1'b0;
            intr_vec   <= 8'h00;
            port_i     <= 8'h00;
            irr        <= '0;
            isr        <= '0;
            imr        <= '0;
            irq_prev   <= '0;
            base_hi    <= VEC_RESET[7:3];
            level_mode <= 1'b0;
            aeoi       <= 1'b0;
            rd_isr     <= 1'b0;
            icw1_sngl  <= 1'b0;
            icw1_ic4   <= 1'b0;
            cfg_state  <= READY;
        end else begin
            irq_prev <= irq_in;
            irr      <= irr_nxt;
            isr      <= isr_nxt;

            if (issue) begin
                intr_vec <= {base_hi, pick_idx};
                intr     <= ~intr_ack;
            end

            if (wr_icw1) begin
                imr        <= '0;
                rd_isr     <= 1'b0;
                aeoi       <= 1'b0;
                level_mode <= port_o[3];
                icw1_sngl  <= port_o[1];
                icw1_ic4   <= port_o[0];
                cfg_state  <= W_ICW2;
            end else if (wr_ocw3 && port_o[1]) begin
                rd_isr <= port_o[0];
            end

            if (wr_data) begin
                case (cfg_state)
                    W_ICW2: begin
                        base_hi <= port_o[7:3];
                        if (!icw1_sngl) begin
                            cfg_state <= W_ICW3;
                        end else if (icw1_ic4) begin
                            cfg_state <= W_ICW4;
                        end else begin
                            cfg_state <= READY;
                        end
                    end
                    W_ICW3: begin
                        cfg_state <= icw1_ic4 ? W_ICW4 : READY;
                    end
                    W_ICW4: begin
                        aeoi      <= port_o[1];
                        cfg_state <= READY;
                    end
                    default: begin
                        imr <= port_o[NUM_IRQ-1:0];
                    end
                endcase
            end

            if (rd_cmd) begin
                port_i <= rd_isr ? isr_rd : irr_rd;
            end else if (rd_data) begin
                port_i <= imr_rd;
            end
        end
    end

endmodule

// File: tb/tb_pic_ctl.sv
`timescale 1ns/1ps
module tb_pic_ctl;

    localparam logic [15:0] BASE = 16'h20;
    localparam logic [15:0] DATA = 16'h21;

    logic       clock = 1'b0;
    logic       resetn;
    logic       port_clk;
    logic [15:0] port;
    logic       port_w;
    logic [7:0] port_o;
    logic [7:0] port_i;
    logic [7:0] irq_in;
    logic       intr;
    logic       intr_ack = 1'b0;
    logic [7:0] intr_vec;

    pic_ctl #(.NUM_IRQ(8), .PORT_BASE(16'h20), .VEC_RESET(8'h08)) dut (
        .clock(clock), .resetn(resetn), .port_clk(port_clk), .port(port),
        .port_w(port_w), .port_o(port_o), .port_i(port_i), .irq_in(irq_in),
        .intr(intr), .intr_ack(intr_ack), .intr_vec(intr_vec)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (one step per clock) ----------------
    int       cyc = 0;
    bit       m_rst = 1'b1;
    bit [7:0] m_irr, m_isr, m_imr, m_prev, m_base, m_vec, m_port_i, m_icw1;
    bit       m_level, m_aeoi, m_sel, m_intr;
    int       m_cfg;   // 0 ready, 1 await ICW2, 2 await ICW3, 3 await ICW4
    int       exp_cyc_q[$];
    bit [7:0] exp_vec_q[$];
    bit [7:0] rd_q[$];

    // highest-priority request that is unmasked and not blocked by any
    // in-service line of equal or higher priority
    function automatic int pick();
        for (int i = 0; i < 8; i++) begin
            if (m_isr[i]) return -1;
            if (m_irr[i] && !m_imr[i]) return i;
        end
        return -1;
    endfunction

    function automatic int lowest_isr();
        for (int i = 0; i < 8; i++) if (m_isr[i]) return i;
        return -1;
    endfunction

    bit [7:0] irr_n, isr_n;
    bit       w_cmd, w_dat, icw1;
    int       n, k;

    always @(posedge clock) begin
        cyc = cyc + 1;
        m_rst = !resetn;
        if (!resetn) begin
            m_irr = 0; m_isr = 0; m_imr = 0; m_base = 8'h08; m_vec = 0; m_port_i = 0;
            m_level = 0; m_aeoi = 0; m_sel = 0; m_intr = 0; m_cfg = 0; m_icw1 = 0;
            m_prev = 0;
        end else begin
            w_cmd = port_clk && port_w && port == BASE;
            w_dat = port_clk && port_w && port == DATA;
            icw1  = w_cmd && port_o[4];
            irr_n = m_irr;
            isr_n = m_isr;
            n = pick();
            if (m_intr == intr_ack && n >= 0 && !icw1) begin
                m_vec  = m_base | 8'(n);
                m_intr = !intr_ack;
                if (!m_level) irr_n[n] = 1'b0;
                if (!m_aeoi) isr_n[n] = 1'b1;
                exp_cyc_q.push_back(cyc);
                exp_vec_q.push_back(m_vec);
            end
            if (port_clk && !port_w) begin
                if (port == BASE) m_port_i = m_sel ? m_isr : m_irr;
                else if (port == DATA) m_port_i = m_imr;
                rd_q.push_back(m_port_i);
            end
            if (w_cmd && port_o[4:3] == 2'b00) begin
                if (port_o[7:5] == 3'b001) begin
                    k = lowest_isr();
                    if (k >= 0) isr_n[k] = 1'b0;
                end else if (port_o[7:5] == 3'b011) begin
                    isr_n[port_o[2:0]] = 1'b0;
                end
            end
            if (w_cmd && port_o[4:3] == 2'b01 && port_o[1]) m_sel = port_o[0];
            if (m_level) irr_n = irq_in;
            else irr_n = irr_n | (irq_in & ~m_prev);
            if (icw1) begin
                irr_n = 0; isr_n = 0; m_imr = 0; m_sel = 0; m_aeoi = 0;
                m_level = port_o[3]; m_icw1 = port_o; m_cfg = 1;
            end else if (w_dat) begin
                case (m_cfg)
                    1: begin
                        m_base = port_o & 8'hF8;
                        m_cfg  = !m_icw1[1] ? 2 : (m_icw1[0] ? 3 : 0);
                    end
                    2: m_cfg = m_icw1[0] ? 3 : 0;
                    3: begin m_aeoi = port_o[1]; m_cfg = 0; end
                    default: m_imr = port_o;
                endcase
            end
            m_irr  = irr_n;
            m_isr  = isr_n;
            m_prev = irq_in;
        end
    end

    // ---------------- monitor + CPU acknowledge ----------------
    logic     last_intr = 1'b0;
    bit [7:0] last_vec = 0;
    int       issue_count = 0;
    int       ack_cnt = -1;
    int       ack_fixed = -1;
    bit [7:0] e_vec, e_rd;
    int       e_cyc;

    always @(negedge clock) begin
        while (rd_q.size() > 0) begin
            e_rd = rd_q.pop_front();
            chk("port_i_read", port_i, e_rd);
        end
        if (m_rst) begin
            last_intr = 1'b0;
            intr_ack  = 1'b0;
            ack_cnt   = -1;
        end else begin
            if (intr !== last_intr) begin
                issue_count++;
                last_vec  = intr_vec;
                last_intr = intr;
                if (exp_vec_q.size() == 0) begin
                    chk("issue_expected", exp_vec_q.size(), 1);
                end else begin
                    e_vec = exp_vec_q.pop_front();
                    e_cyc = exp_cyc_q.pop_front();
                    chk("issue_vec", intr_vec, e_vec);
                    chk("issue_cycle", cyc, e_cyc);
                end
                ack_cnt = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, 3));
            end
            if (ack_cnt == 0) begin
                intr_ack = last_intr;
                ack_cnt  = -1;
            end else if (ack_cnt > 0) begin
                ack_cnt--;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int c);
        repeat (c) @(negedge clock);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        port = a; port_o = d; port_w = 1'b1; port_clk = 1'b1;
        @(negedge clock);
        port_clk = 1'b0; port_w = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string name);
        port = a; port_w = 1'b0; port_clk = 1'b1;
        @(negedge clock);
        port_clk = 1'b0;
        chk(name, port_i, exp);
    endtask

    task automatic pulse(input logic [7:0] m);
        irq_in = irq_in | m;
        @(negedge clock);
        irq_in = irq_in & ~m;
    endtask

    task automatic wait_issue(input int c0, input logic [7:0] exp, input string name);
        for (int i = 0; i < 40; i++) begin
            if (issue_count != c0) break;
            @(negedge clock);
        end
        if (issue_count == c0) chk({name, "_timeout"}, 0, 1);
        else chk(name, last_vec, exp);
    endtask

    task automatic no_issue(input int c, input string name);
        int c0;
        c0 = issue_count;
        idle(c);
        chk(name, issue_count, c0);
    endtask

    task automatic init(input logic [7:0] icw1_v, input logic [7:0] icw4_v);
        wr(BASE, icw1_v);
        wr(DATA, 8'h08);
        wr(DATA, icw4_v);
    endtask

    int       c0, c1, r;
    bit [7:0] b;

    initial begin
        resetn = 1'b0; port_clk = 1'b0; port = 16'h0; port_w = 1'b0; port_o = 8'h0; irq_in = 8'h0;
        idle(3);
        chk("rst_intr", intr, 0);
        chk("rst_vec", intr_vec, 8'h00);
        chk("rst_port_i", port_i, 8'h00);
        resetn = 1'b1;
        rd(DATA, 8'h00, "rst_imr");
        rd(BASE, 8'h00, "rst_irr");

        // basic edge request on line 0
        init(8'h13, 8'h01);
        c0 = issue_count; pulse(8'h01);
        wait_issue(c0, 8'h08, "vec_line0");
        wr(BASE, 8'h0B);
        rd(BASE, 8'h01, "isr_line0");
        wr(BASE, 8'h20);

        // preemption: line 1 while line 3 in service
        c0 = issue_count; pulse(8'h08);
        wait_issue(c0, 8'h0B, "vec_line3");
        c0 = issue_count; pulse(8'h02);
        wait_issue(c0, 8'h09, "vec_preempt1");
        rd(BASE, 8'h0A, "isr_nested");
        wr(BASE, 8'h20);
        rd(BASE, 8'h08, "isr_after_nseoi");
        wr(BASE, 8'h63);
        rd(BASE, 8'h00, "isr_after_seoi");

        // masking and priority
        wr(DATA, 8'h01);
        c0 = issue_count; pulse(8'h05);
        wait_issue(c0, 8'h0A, "vec_masked_prio");
        no_issue(8, "masked_line0_held");
        wr(BASE, 8'h62);
        c0 = issue_count; wr(DATA, 8'h00);
        wait_issue(c0, 8'h08, "vec_unmasked0");
        wr(BASE, 8'h20);
        rd(DATA, 8'h00, "imr_zero");

        // auto-EOI, second request waits on the acknowledge
        init(8'h13, 8'h03);
        ack_fixed = 6;
        c0 = issue_count; pulse(8'h10);
        wait_issue(c0, 8'h0C, "vec_aeoi");
        c1 = issue_count; pulse(8'h10);
        wait_issue(c1, 8'h0C, "vec_aeoi_second");
        ack_fixed = -1;
        wr(BASE, 8'h0B);
        rd(BASE, 8'h00, "isr_aeoi");
        idle(10);

        // level mode
        init(8'h1B, 8'h01);
        c0 = issue_count; irq_in = 8'h20;
        wait_issue(c0, 8'h0D, "vec_level");
        no_issue(10, "level_single_issue");
        c0 = issue_count; wr(BASE, 8'h20);
        wait_issue(c0, 8'h0D, "vec_level_reissue");
        irq_in = 8'h00;
        wr(BASE, 8'h0A);
        rd(BASE, 8'h00, "irr_level_drop");
        wr(BASE, 8'h20);
        idle(6);

        // randomized traffic, checked by the model only
        init(8'h13, ($urandom_range(0, 1) != 0) ? 8'h03 : 8'h01);
        for (int i = 0; i < 600; i++) begin
            irq_in = 8'($urandom & $urandom & $urandom);
            r = int'($urandom_range(0, 9));
            b = 8'($urandom);
            port_w = 1'b0; port_clk = 1'b1;
            case (r)
                0: begin port = BASE; port_w = 1'b1; port_o = 8'h20; end
                1: begin port = BASE; port_w = 1'b1; port_o = {3'b011, 2'b00, b[2:0]}; end
                2: begin port = BASE; port_w = 1'b1; port_o = {b[7:5], 2'b00, b[2:0]}; end
                3: begin port = DATA; port_w = 1'b1; port_o = b & 8'($urandom); end
                4: port = BASE;
                5: port = DATA;
                6: begin port = BASE; port_w = 1'b1; port_o = {b[7:5], 2'b01, b[2:0]}; end
                7: begin port = 16'h22; port_w = 1'b1; port_o = b; end
                8: port = 16'h0120;
                default: port_clk = 1'b0;
            endcase
            @(negedge clock);
            port_clk = 1'b0; port_w = 1'b0;
        end
        irq_in = 8'h00;
        idle(10);

        // reset while a request is outstanding
        init(8'h13, 8'h01);
        idle(8);
        ack_fixed = 1000;
        wr(DATA, 8'hF0);
        c0 = issue_count; pulse(8'h01);
        wait_issue(c0, 8'h08, "vec_before_reset");
        resetn = 1'b0;
        @(negedge clock);
        chk("reset_intr", intr, 0);
        chk("reset_vec", intr_vec, 8'h00);
        resetn = 1'b1;
        ack_fixed = -1;
        rd(DATA, 8'h00, "reset_imr");

        idle(20);
        chk("exp_q_drained", exp_vec_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
